// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // System clocks per line bit; truncating division, shared with the transmitter.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset level is configurable.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, one-entry valid/ready output
// with a frame-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 half_tick, bit_tick;
  logic                 shift_en, load_byte, ferr_set;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rx_s)
  );

  assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
  assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign busy      = (state != RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      RX_IDLE:  if (!rx_s) state_nxt = RX_START;
      RX_START: if (half_tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            load_byte = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = RX_BREAK;
          end
        end
      end
      RX_BREAK: if (rx_s) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // The counter also restarts at each data-bit boundary so non-power-of-two bit periods stay exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state_nxt != state) || shift_en ||
                 (state == RX_IDLE) || (state == RX_BREAK)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      if (state == RX_START) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        shift_q[bit_idx] <= rx_s;
        if (bit_idx != IDX_W'(DATA_BITS - 1)) bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (load_byte) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A concurrent set takes priority over the clear.
      if (load_byte && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (ovr_clr)                        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  int       cyc = 0;
  int       t_fall = 0;
  int       t_rise = 0;
  int       ferr_cnt = 0;
  int       acc_cnt = 0;
  logic [7:0] acc_byte = '0;
  logic     busy_seen = 1'b0;
  logic     prev_v = 1'b0;

  uart_rx #(.CLK_FREQ(1600000), .BAUD_RATE(100000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && rx_ready) begin
      acc_cnt  = acc_cnt + 1;
      acc_byte = rx_data;
    end
    if (rx_valid && !prev_v) t_rise = cyc;
    prev_v = rx_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    t_fall = cyc;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 16);
    drive_bit(stop, 16);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
    int         exp_acc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 0, 1};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1, 0};
    vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 0, 0};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 0, 0};
    vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0, 0};

    // Reset state
    wait_cycles(3);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Valid frame, held until consumed; rx_valid edge timing
    rx_ready = 1'b0;
    ferr_cnt = 0;
    send_frame(8'hA5, 1'b1);
    chk("t1_latency", t_rise - t_fall, 155);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    wait_cycles(5);
    chk("t1_hold_valid", rx_valid, 1);
    chk("t1_hold_data", rx_data, 8'hA5);
    rx_ready = 1'b1;
    #2;
    chk("t1_valid_before_edge", rx_valid, 1);
    wait_cycles(1);
    chk("t1_consumed", rx_valid, 0);
    rx_ready = 1'b0;
    chk("t1_no_ferr", ferr_cnt, 0);

    // Start-bit glitch
    busy_seen = 1'b0;
    ferr_cnt = 0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 20);
    chk("t2_busy_seen", busy_seen, 1);
    chk("t2_busy_idle", busy, 0);
    chk("t2_valid", rx_valid, 0);
    chk("t2_ferr", ferr_cnt, 0);

    // Frame table
    for (int i = 0; i < 6; i++) begin
      rx_ready = vecs[i].ready;
      ferr_cnt = 0;
      acc_cnt  = 0;
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        busy_seen = 1'b0;
        drive_bit(1'b0, 48);
        chk($sformatf("v%0d_break_busy", i), busy, 1);
        chk($sformatf("v%0d_break_valid", i), rx_valid, 0);
        drive_bit(1'b1, 16);
        chk($sformatf("v%0d_break_idle", i), busy, 0);
      end
      chk($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ovr);
      chk($sformatf("v%0d_ferr_cycles", i), ferr_cnt, vecs[i].exp_ferr);
      chk($sformatf("v%0d_accepts", i), acc_cnt, vecs[i].exp_acc);
      if (vecs[i].exp_acc != 0)
        chk($sformatf("v%0d_acc_byte", i), acc_byte, vecs[i].data);
    end
    rx_ready = 1'b0;

    // Overrun clear, then consume
    ovr_clr = 1'b1;
    wait_cycles(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_valid_kept", rx_valid, 1);
    chk("ovr_data_kept", rx_data, 8'h22);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    chk("ovr_consumed", rx_valid, 0);

    // Set up a pending byte and overrun, then reset during bit 3 of 0x5A
    send_frame(8'h77, 1'b1);
    send_frame(8'h66, 1'b1);
    chk("t6_pre_ovr", overrun, 1);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 6);
    chk("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rx_data", rx_data, 0);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_frame_err", frame_err, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_busy", busy, 0);
    wait_cycles(3);
    rst_n = 1'b1;
    drive_bit(1'b1, 20);
    chk("t6_idle", busy, 0);
    ferr_cnt = 0;
    send_frame(8'h81, 1'b1);
    chk("t6_valid", rx_valid, 1);
    chk("t6_data", rx_data, 8'h81);
    chk("t6_ferr", ferr_cnt, 0);
    chk("t6_no_ovr", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the UART link: 8N1 frames in, parallel bytes out.
- Runs on the single system clock; bit timing comes from an internal counter clock-enable, not a divided clock.
- Sits opposite the transmit path. Input is the asynchronous serial pin; output is a one-entry valid/ready byte interface with frame-error and overrun status.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer truncation (default 868).
- Derived localparam HALF_BIT = CLKS_PER_BIT/2.
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a new byte overwrote an unconsumed byte.
- ovr_clr  input  1  synchronous clear of overrun.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Reset also sets: state=IDLE, both synchronizer flops=1, counters=0.
- Synchronizer: rxd passes through 2 flops to give rx_s. All decisions use rx_s only.
- Bit counter cnt: counts clk cycles within a phase and clears on every state transition.
- IDLE: rx_s==0 -> START.
- START: at cnt==HALF_BIT-1, sample rx_s.
  - 0 -> DATA, bit_idx=0.
  - 1 -> IDLE. This is a glitch: no flags, no data.
- DATA: at each cnt==CLKS_PER_BIT-1, shift[bit_idx]=rx_s (LSB first).
  - After bit_idx==7 -> STOP; otherwise bit_idx++.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1 -> rx_data=shift, rx_valid=1, then IDLE.
  - 0 -> frame_err=1 for exactly one cycle; rx_data and rx_valid unchanged; -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. A held-low line never restarts a frame.
- Timing: rx_valid rises on the same edge as the stop-bit sample.
  - That edge is HALF_BIT + 9*CLKS_PER_BIT cycles after START is entered.
  - START is entered 3 cycles after rxd falls (2 synchronizer + 1 IDLE detect).
- Handshake:
  - rx_valid & rx_ready clears rx_valid on the next edge.
  - rx_data stays stable while rx_valid=1, unless an overrun occurs.
- Simultaneous load and consume (same cycle): new byte loaded, rx_valid stays 1, no overrun.
- Load while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, overrun is set.
- overrun: cleared only by ovr_clr or reset. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: immediate abort to reset values. The partial byte is discarded.
- Receive is always enabled. A frame is received regardless of rx_valid.

Decomposition:
- Package uart_pkg holds:
  - rx state encoding: IDLE, START, DATA, STOP, BREAK.
  - DATA_BITS=8.
  - A function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE, shared with the transmitter.
- One sub-module is natural: uart_sync_2ff, the 2-flop synchronizer.
  - Reset value is a parameter; 1 here.
  - Reusable for other asynchronous inputs.

Test Plan:
All tests use CLK_FREQ=1600000, BAUD_RATE=100000, giving CLKS_PER_BIT=16 and HALF_BIT=8.
1. Valid frame 0xA5, rx_ready=0 -> rx_valid=1 and rx_data=0xA5 at the expected edge; rx_valid holds until rx_ready=1, then clears next cycle; frame_err never asserts.
2. rxd low for 4 cycles, then high -> busy pulses; returns to IDLE; rx_valid=0, frame_err=0.
3. Frame 0x3C with stop bit 0, line held low for 48 cycles -> frame_err high exactly 1 cycle; rx_valid stays 0; no new frame while low. Line high, then frame 0x55 -> rx_data=0x55.
4. Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x22, rx_valid=1, overrun=1. Pulse ovr_clr -> overrun=0 next cycle.
5. Back-to-back frames 0x00 and 0xFF, rx_ready tied 1 -> two 1-cycle rx_valid pulses with rx_data 0x00 then 0xFF; overrun=0.
6. rst_n pulsed low during bit 3 of 0x5A -> all outputs at reset values immediately. Next frame 0x81 -> rx_data=0x81, frame_err=0.
